// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, default widths and the no-hit marker for the frame sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
  localparam int FRAME_W_DEF = 18;
  localparam int LEN_W_DEF = 5;
  localparam logic [LEN_W_DEF-1:0] NO_HIT = '1;
endpackage

// File: rtl/seq_hit_counter.sv
// seq_hit_counter: saturating hit tally plus capture of the bit index at the first hit
module seq_hit_counter #(
  parameter int CNT_W = 5,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             det_i,
  input  logic [LEN_W-1:0] idx_i,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [LEN_W-1:0] first_hit_pos_o,
  output logic             hit_seen_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] pos_q, pos_d;
  logic seen_q, seen_d, hit;
  assign hit = en_i && det_i;
  // clear on a new frame, otherwise count hits without wrapping and latch the first position
  always_comb begin
    cnt_d = clr_i ? '0 : hit && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    pos_d = clr_i ? '1 : hit && !seen_q ? idx_i : pos_q;
    seen_d = !clr_i && (seen_q || hit);
  end
  // result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pos_q <= '1;
      seen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      seen_q <= seen_d;
    end
  end
  assign hit_count_o = cnt_q;
  assign first_hit_pos_o = pos_q;
  assign hit_seen_o = seen_q;
endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: shifts a captured frame out on seq_o and tallies detector hits over the frame
module seq_stream_ctrl
  import seq_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = 5,
  parameter int DRAIN_CYC = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [FRAME_W-1:0] frame_data_i,
  input  logic [LEN_W-1:0]   frame_len_i,
  output logic               seq_o,
  input  logic               det_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   hit_count_o,
  output logic [LEN_W-1:0]   first_hit_pos_o,
  output logic               hit_seen_o
);
  localparam int DW = DRAIN_CYC > 0 ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FRAME_W);
  state_e state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d, len_in;
  logic [DW-1:0] drain_q, drain_d;
  logic [FRAME_W-1:0] sr_q, sr_d, cap, src;
  logic seq_q, seq_d, accept, last, run;
  assign len_in = frame_len_i > MAX_LEN ? MAX_LEN : frame_len_i;
  assign accept = state_q == IDLE && start_i;
  assign last = idx_q == len_q - 1'b1;
  assign run = state_q == SHIFT || state_q == DRAIN;
  // MSB-first frames are pre-aligned once at capture so bit len-1 sits at the top of the shifter
  assign cap = LSB_FIRST ? frame_data_i : frame_data_i << (MAX_LEN - len_in);
  assign src = accept ? cap : sr_q;
  // state, shifter and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      drain_q <= '0;
      sr_q <= '0;
      seq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      drain_q <= drain_d;
      sr_q <= sr_d;
      seq_q <= seq_d;
    end
  end
  // next state: abort beats progress, the last bit leads into the drain window
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start_i ? IDLE : len_in == '0 ? DONE : SHIFT;
      SHIFT:   state_d = abort_i ? IDLE : !last ? SHIFT : DRAIN_CYC == 0 ? DONE : DRAIN;
      DRAIN:   state_d = abort_i ? IDLE : drain_q == DW'(1) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // datapath next values; idx_q parks at len-1 through the drain so it doubles as the hit position
  always_comb begin
    idx_d = accept ? '0 : state_q == SHIFT && !last ? idx_q + 1'b1 : idx_q;
    len_d = accept ? len_in : len_q;
    drain_d = state_q == SHIFT ? DW'(DRAIN_CYC) : state_q == DRAIN ? drain_q - 1'b1 : drain_q;
    sr_d = accept || state_q == SHIFT ? (LSB_FIRST ? src >> 1 : src << 1) : sr_q;
    seq_d = state_d == SHIFT && (LSB_FIRST ? src[0] : src[FRAME_W-1]);
  end
  assign seq_o = seq_q;
  assign busy_o = run;
  assign done_o = state_q == DONE;
  seq_hit_counter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) u_hits (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (accept),
    .en_i            (run),
    .det_i           (det_in_i),
    .idx_i           (idx_q),
    .hit_count_o     (hit_count_o),
    .first_hit_pos_o (first_hit_pos_o),
    .hit_seen_o      (hit_seen_o)
  );
endmodule
